// File: rtl/tx_rate_adapt_2g_5g_if.sv
// FIFO-side and XGMII-side signal bundle for tx_rate_adapt_2g_5g.
// slave = adapter view, master = FIFO/PCS environment view.
interface tx_rate_adapt_2g_5g_if #(
  parameter int BCNT_W = 16
) ();
  logic              mode_10G;
  logic              mode_5G;
  logic              mode_2p5G;
  logic              mode_1G;
  logic [63:0]       fifo_data;
  logic [7:0]        fifo_ctrl;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [63:0]       data_out;
  logic [7:0]        ctrl_out;
  logic [BCNT_W-1:0] tx_byte_cnt;
  logic              tx_bcnt_we;
  logic              underrun;
  logic              in_frame;

  modport slave (
    input  mode_10G, mode_5G, mode_2p5G, mode_1G,
    input  fifo_data, fifo_ctrl, fifo_empty,
    output fifo_rd, data_out, ctrl_out,
    output tx_byte_cnt, tx_bcnt_we,
    output underrun, in_frame
  );

  modport master (
    output mode_10G, mode_5G, mode_2p5G, mode_1G,
    output fifo_data, fifo_ctrl, fifo_empty,
    input  fifo_rd, data_out, ctrl_out,
    input  tx_byte_cnt, tx_bcnt_we,
    input  underrun, in_frame
  );
endinterface

// File: rtl/tx_rate_adapt_2g_5g.sv
// TX rate adapter: replays FIFO words for 1/2/4-cycle slots (10G/5G/2.5G).
// Macro TX_UNDERRUN_ERR_EN: underrun slot emits 0xFE error word, else idle.
module tx_rate_adapt_2g_5g #(
  parameter int BCNT_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  tx_rate_adapt_2g_5g_if.slave bus
);

  localparam int CW = BCNT_W - 1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [63:0] IDLE_D = {8{8'h07}};
`ifdef TX_UNDERRUN_ERR_EN
  localparam logic [63:0] UNDR_D = {8{8'hFE}};
`else
  localparam logic [63:0] UNDR_D = IDLE_D;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    mode, mode_q;
  logic [1:0]    slot_q, slot_d;
  logic [1:0]    last_slot;
  logic [63:0]   data_q, data_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic          we_q, we_d;
  logic          un_q, un_d;

  logic          active, mode_chg;
  logic          bnd, rd;
  logic          s0, s4, start;
  logic          has_t, split;
  logic [2:0]    tk;
  logic [CW-1:0] open_cnt, close_cnt;

  function automatic logic [CW-1:0] sat_add(
    input logic [CW-1:0] a,
    input logic [3:0]    b
  );
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-3){1'b0}}, b};
    return s[CW] ? CMAX : s[CW-1:0];
  endfunction

  assign mode = {bus.mode_10G, bus.mode_5G,
                 bus.mode_2p5G, bus.mode_1G};
  assign active = bus.mode_10G | bus.mode_5G
                | bus.mode_2p5G;
  assign mode_chg = (mode != mode_q);

  always_comb begin
    last_slot = 2'd3;
    if (bus.mode_10G)     last_slot = 2'd0;
    else if (bus.mode_5G) last_slot = 2'd1;
  end

  assign bnd = (slot_q == 2'd0);
  assign rd  = active & ~reset & bnd
             & ~bus.fifo_empty & ~mode_chg;
  assign bus.fifo_rd = rd;

  assign s0 = (bus.fifo_data[7:0] == 8'hFB)
            & bus.fifo_ctrl[0];
  assign s4 = (bus.fifo_data[39:32] == 8'hFB)
            & bus.fifo_ctrl[4];
  assign start = s0 | s4;

  // Lowest terminate lane wins
  always_comb begin
    has_t = 1'b0;
    tk    = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.fifo_data[8*k +: 8] == 8'hFD
          && bus.fifo_ctrl[k]) begin
        has_t = 1'b1;
        tk    = 3'(k);
      end
    end
  end

  // Term in lower half plus lane-4 start: close and reopen
  assign split = s4 & ~s0 & has_t & ~tk[2];
  assign open_cnt  = s0 ? CW'(8) : CW'(4);
  assign close_cnt = sat_add(cnt_q, {1'b0, tk} + 4'd1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    bcnt_d  = bcnt_q;
    we_d    = 1'b0;
    un_d    = 1'b0;
    if (!active || mode_chg) begin
      state_d = S_IDLE;
      slot_d  = 2'd0;
      data_d  = IDLE_D;
      ctrl_d  = 8'hFF;
      cnt_d   = '0;
      flag_d  = 1'b0;
    end else begin
      slot_d = (slot_q == last_slot) ? 2'd0
             : slot_q + 2'd1;
      if (bnd && bus.fifo_empty) begin
        data_d = IDLE_D;
        ctrl_d = 8'hFF;
        if (state_q == S_FRAME) begin
          state_d = S_DROP;
          un_d    = 1'b1;
          data_d  = UNDR_D;
        end
      end else if (bnd) begin
        data_d = bus.fifo_data;
        ctrl_d = bus.fifo_ctrl;
        if (state_q == S_FRAME) begin
          if (split) begin
            bcnt_d = {flag_q, close_cnt};
            we_d   = 1'b1;
            cnt_d  = CW'(4);
            flag_d = 1'b1;
          end else if (start) begin
            cnt_d  = open_cnt;
            flag_d = ~s0;
          end else if (has_t) begin
            bcnt_d  = {flag_q, close_cnt};
            we_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = sat_add(cnt_q, 4'd8);
          end
        end else if (start) begin
          state_d = S_FRAME;
          cnt_d   = open_cnt;
          flag_d  = ~s0;
        end else if (state_q == S_DROP) begin
          data_d = IDLE_D;
          ctrl_d = 8'hFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= mode;
      slot_q  <= 2'd0;
      data_q  <= IDLE_D;
      ctrl_q  <= 8'hFF;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      bcnt_q  <= '0;
      we_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      slot_q  <= slot_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      bcnt_q  <= bcnt_d;
      we_q    <= we_d;
      un_q    <= un_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.ctrl_out    = ctrl_q;
  assign bus.tx_byte_cnt = bcnt_q;
  assign bus.tx_bcnt_we  = we_q;
  assign bus.underrun    = un_q;
  assign bus.in_frame    = (state_q == S_FRAME);

endmodule

// File: tb/tb_tx_rate_adapt_2g_5g.sv
// Bench for tx_rate_adapt_2g_5g: slot-level reference model, scripted FIFO.
// Honours TX_UNDERRUN_ERR_EN for the expected underrun word.
module tb_tx_rate_adapt_2g_5g;

  localparam logic [63:0] IDLE_D = {8{8'h07}};
`ifdef TX_UNDERRUN_ERR_EN
  localparam logic [63:0] UNDR_D = {8{8'hFE}};
`else
  localparam logic [63:0] UNDR_D = IDLE_D;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tx_rate_adapt_2g_5g_if #(.BCNT_W(16)) bus ();

  tx_rate_adapt_2g_5g #(.BCNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          emp;
    logic [63:0] d;
    logic [7:0]  c;
  } item_t;

  item_t script[$];
  int checks = 0;
  int errors = 0;

  // Reference model: one step per slot
  int          m_st;
  int          m_cnt;
  bit          m_flag;
  logic [15:0] m_last;
  int          m_we_cnt;
  logic [63:0] e_d;
  logic [7:0]  e_c;
  bit          e_we, e_un;

  int          we_seen, un_seen;
  logic [15:0] bcnt_seen, bcnt_first;

  function automatic item_t w_empty();
    item_t it;
    it.emp = 1'b1;
    it.d   = '0;
    it.c   = '0;
    return it;
  endfunction

  function automatic item_t w_data();
    item_t it;
    it.emp = 1'b0;
    it.c   = 8'h00;
    for (int j = 0; j < 8; j++)
      it.d[8*j +: 8] = 8'($urandom_range(0, 255));
    return it;
  endfunction

  function automatic item_t w_idle();
    item_t it;
    it.emp = 1'b0;
    it.d   = IDLE_D;
    it.c   = 8'hFF;
    return it;
  endfunction

  function automatic item_t w_start(input bit l4);
    item_t it;
    it = w_data();
    if (!l4) begin
      it.d[7:0] = 8'hFB;
      it.c      = 8'h01;
    end else begin
      it.d[31:0]  = {4{8'h07}};
      it.d[39:32] = 8'hFB;
      it.c        = 8'h1F;
    end
    return it;
  endfunction

  function automatic item_t w_term(input int k);
    item_t it;
    it = w_data();
    for (int j = 0; j < 8; j++) begin
      if (j == k) begin
        it.d[8*j +: 8] = 8'hFD;
        it.c[j] = 1'b1;
      end else if (j > k) begin
        it.d[8*j +: 8] = 8'h07;
        it.c[j] = 1'b1;
      end
    end
    return it;
  endfunction

  function automatic item_t w_split(input int k);
    item_t it;
    it = w_term(k);
    it.d[39:32] = 8'hFB;
    it.c[4] = 1'b1;
    it.c[7:5] = 3'b000;
    return it;
  endfunction

  function automatic item_t head();
    if (script.size() > 0) return script[0];
    return w_empty();
  endfunction

  task automatic set_mode(input int p);
    bus.mode_10G  = (p == 1);
    bus.mode_5G   = (p == 2);
    bus.mode_2p5G = (p == 4);
    bus.mode_1G   = 1'b0;
  endtask

  task automatic drive(input item_t h);
    bus.fifo_empty = h.emp;
    bus.fifo_data  = h.d;
    bus.fifo_ctrl  = h.c;
  endtask

  task automatic m_close(input int tk);
    int v;
    v = m_cnt + tk + 1;
    if (v > 32767) v = 32767;
    m_last = {m_flag, 15'(v)};
    e_we = 1'b1;
    m_we_cnt++;
  endtask

  task automatic m_open(input bit s0);
    m_cnt  = s0 ? 8 : 4;
    m_flag = !s0;
  endtask

  task automatic model_slot(input item_t it);
    bit s0, s4;
    int tk;
    e_we = 1'b0;
    e_un = 1'b0;
    if (it.emp) begin
      e_d = IDLE_D;
      e_c = 8'hFF;
      if (m_st == 1) begin
        m_st = 2;
        e_un = 1'b1;
        e_d  = UNDR_D;
      end
      return;
    end
    s0 = (it.d[7:0] == 8'hFB) && it.c[0];
    s4 = (it.d[39:32] == 8'hFB) && it.c[4];
    tk = -1;
    for (int j = 7; j >= 0; j--)
      if (it.d[8*j +: 8] == 8'hFD && it.c[j]) tk = j;
    e_d = it.d;
    e_c = it.c;
    if (m_st == 1) begin
      if (s4 && !s0 && tk >= 0 && tk < 4) begin
        m_close(tk);
        m_cnt  = 4;
        m_flag = 1'b1;
      end else if (s0 || s4) begin
        m_open(s0);
      end else if (tk >= 0) begin
        m_close(tk);
        m_st = 0;
      end else begin
        m_cnt = (m_cnt + 8 > 32767) ? 32767 : m_cnt + 8;
      end
    end else if (s0 || s4) begin
      m_open(s0);
      m_st = 1;
    end else if (m_st == 2) begin
      e_d = IDLE_D;
      e_c = 8'hFF;
    end
  endtask

  task automatic clear_obs();
    we_seen = 0;
    un_seen = 0;
    m_we_cnt = 0;
    bcnt_seen = '0;
    bcnt_first = '0;
  endtask

  // Called at a negedge; returns at a negedge
  task automatic run(input int p, input bit do_rst,
                     input int ncyc);
    item_t h;
    bit bnd;
    bit exp_rd;
    set_mode(p);
    if (do_rst) begin
      reset = 1'b1;
      drive(w_empty());
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_last = '0;
    end else begin
      drive(head());
      #1;
      checks++;
      if (bus.fifo_rd !== 1'b0)
        $display("FAIL mode_chg_rd: got %b exp 0",
                 bus.fifo_rd);
      if (bus.fifo_rd !== 1'b0) errors++;
      @(posedge clk);
      #1;
      checks++;
      if (bus.data_out !== IDLE_D || bus.ctrl_out !== 8'hFF
          || bus.in_frame !== 1'b0) begin
        errors++;
        $display("FAIL mode_chg_idle: got %h/%h/%b exp %h/ff/0",
                 bus.data_out, bus.ctrl_out, bus.in_frame,
                 IDLE_D);
      end
      checks++;
      if (bus.tx_bcnt_we !== 1'b0 || bus.underrun !== 1'b0) begin
        errors++;
        $display("FAIL mode_chg_strobe: got we=%b un=%b exp 0/0",
                 bus.tx_bcnt_we, bus.underrun);
      end
      @(negedge clk);
    end
    m_st = 0;
    m_cnt = 0;
    m_flag = 1'b0;
    e_d = IDLE_D;
    e_c = 8'hFF;
    e_we = 1'b0;
    e_un = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      h = head();
      drive(h);
      bnd = ((c % p) == 0);
      exp_rd = bnd && !h.emp;
      #1;
      checks++;
      if (bus.fifo_rd !== exp_rd) begin
        errors++;
        $display("FAIL fifo_rd cyc %0d: got %b exp %b",
                 c, bus.fifo_rd, exp_rd);
      end
      @(posedge clk);
      if (bnd) begin
        if (script.size() > 0) void'(script.pop_front());
        model_slot(h);
      end else begin
        e_we = 1'b0;
        e_un = 1'b0;
      end
      #1;
      if (bus.tx_bcnt_we === 1'b1) begin
        if (we_seen == 0) bcnt_first = bus.tx_byte_cnt;
        we_seen++;
        bcnt_seen = bus.tx_byte_cnt;
      end
      if (bus.underrun === 1'b1) un_seen++;
      checks++;
      if (bus.data_out !== e_d || bus.ctrl_out !== e_c) begin
        errors++;
        $display("FAIL xgmii cyc %0d: got %h/%h exp %h/%h",
                 c, bus.data_out, bus.ctrl_out, e_d, e_c);
      end
      checks++;
      if (bus.in_frame !== (m_st == 1)) begin
        errors++;
        $display("FAIL in_frame cyc %0d: got %b exp %b",
                 c, bus.in_frame, (m_st == 1));
      end
      checks++;
      if (bus.tx_bcnt_we !== e_we || bus.underrun !== e_un) begin
        errors++;
        $display("FAIL strobes cyc %0d: got we=%b un=%b exp %b/%b",
                 c, bus.tx_bcnt_we, bus.underrun, e_we, e_un);
      end
      checks++;
      if (bus.tx_byte_cnt !== m_last) begin
        errors++;
        $display("FAIL byte_cnt cyc %0d: got %h exp %h",
                 c, bus.tx_byte_cnt, m_last);
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_counts(input string nm, input int we_n,
                               input int un_n,
                               input logic [15:0] bc);
    checks++;
    if (we_seen != we_n || un_seen != un_n) begin
      errors++;
      $display("FAIL %s pulses: got we=%0d un=%0d exp %0d/%0d",
               nm, we_seen, un_seen, we_n, un_n);
    end
    checks++;
    if (bcnt_seen !== bc) begin
      errors++;
      $display("FAIL %s bcnt: got %h exp %h", nm, bcnt_seen, bc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_mode(2);
    reset = 1'b1;
    drive(w_start(1'b0));
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_out !== IDLE_D || bus.ctrl_out !== 8'hFF) begin
      errors++;
      $display("FAIL rst_xgmii: got %h/%h exp %h/ff",
               bus.data_out, bus.ctrl_out, IDLE_D);
    end
    checks++;
    if (bus.fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd: got %b exp 0", bus.fifo_rd);
    end
    checks++;
    if (bus.tx_byte_cnt !== 16'h0 || bus.tx_bcnt_we !== 1'b0
        || bus.underrun !== 1'b0 || bus.in_frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_status: got %h %b %b %b exp 0 0 0 0",
               bus.tx_byte_cnt, bus.tx_bcnt_we, bus.underrun,
               bus.in_frame);
    end
    @(negedge clk);
  endtask

  task automatic test_5g_frame();
    clear_obs();
    script.delete();
    script.push_back(w_start(1'b0));
    script.push_back(w_data());
    script.push_back(w_term(3));
    run(2, 1'b1, 10);
    expect_counts("5g_frame", 1, 0, 16'h0014);
  endtask

  task automatic test_2g5_lane4();
    clear_obs();
    script.delete();
    script.push_back(w_start(1'b1));
    script.push_back(w_data());
    script.push_back(w_term(0));
    run(4, 1'b1, 16);
    expect_counts("2g5_lane4", 1, 0, 16'h800D);
  endtask

  task automatic test_back_to_back();
    clear_obs();
    script.delete();
    script.push_back(w_empty());
    script.push_back(w_empty());
    script.push_back(w_start(1'b0));
    script.push_back(w_term(5));
    run(1, 1'b1, 8);
    expect_counts("10g_b2b", 1, 0, 16'h000E);
  endtask

  task automatic test_underrun();
    clear_obs();
    script.delete();
    script.push_back(w_start(1'b0));
    script.push_back(w_empty());
    script.push_back(w_data());
    script.push_back(w_term(3));
    script.push_back(w_data());
    script.push_back(w_start(1'b0));
    script.push_back(w_term(1));
    run(2, 1'b1, 18);
    expect_counts("underrun", 1, 1, 16'h000A);
  endtask

  task automatic test_split();
    clear_obs();
    script.delete();
    script.push_back(w_start(1'b0));
    script.push_back(w_data());
    script.push_back(w_split(2));
    script.push_back(w_term(7));
    run(2, 1'b1, 12);
    expect_counts("split", 2, 0, 16'h800C);
    checks++;
    if (bcnt_first !== 16'h0013) begin
      errors++;
      $display("FAIL split_first: got %h exp 0013", bcnt_first);
    end
  endtask

  task automatic test_reset_mode();
    clear_obs();
    script.delete();
    script.push_back(w_start(1'b0));
    for (int i = 0; i < 5; i++) script.push_back(w_data());
    script.push_back(w_term(4));
    run(2, 1'b1, 5);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rd: got %b exp 0", bus.fifo_rd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_out !== IDLE_D || bus.ctrl_out !== 8'hFF
        || bus.in_frame !== 1'b0 || bus.tx_bcnt_we !== 1'b0
        || bus.underrun !== 1'b0
        || bus.tx_byte_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midrst_out: got %h/%h f%b w%b u%b c%h",
               bus.data_out, bus.ctrl_out, bus.in_frame,
               bus.tx_bcnt_we, bus.underrun, bus.tx_byte_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    m_last = '0;
    run(4, 1'b0, 4 * script.size() + 8);
    expect_counts("rst_mode", 0, 0, 16'h0000);
  endtask

  task automatic test_inactive();
    @(negedge clk);
    bus.mode_10G  = 1'b0;
    bus.mode_5G   = 1'b0;
    bus.mode_2p5G = 1'b0;
    bus.mode_1G   = 1'b1;
    drive(w_start(1'b0));
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.fifo_rd !== 1'b0) begin
        errors++;
        $display("FAIL inactive_rd %0d: got %b exp 0",
                 i, bus.fifo_rd);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.data_out !== IDLE_D || bus.ctrl_out !== 8'hFF
          || bus.in_frame !== 1'b0) begin
        errors++;
        $display("FAIL inactive_out %0d: got %h/%h/%b exp idle",
                 i, bus.data_out, bus.ctrl_out, bus.in_frame);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int p;
    int nf;
    for (int it = 0; it < 8; it++) begin
      clear_obs();
      script.delete();
      case ($urandom_range(0, 2))
        0: p = 1;
        1: p = 2;
        default: p = 4;
      endcase
      nf = $urandom_range(3, 5);
      for (int f = 0; f < nf; f++) begin
        repeat ($urandom_range(0, 2)) script.push_back(w_empty());
        if ($urandom_range(0, 3) == 0) script.push_back(w_idle());
        script.push_back(w_start(1'($urandom_range(0, 1))));
        if ($urandom_range(0, 5) == 0) script.push_back(w_empty());
        repeat ($urandom_range(0, 3)) script.push_back(w_data());
        script.push_back(w_term($urandom_range(0, 7)));
      end
      run(p, 1'b1, p * script.size() + 3 * p);
      checks++;
      if (we_seen != m_we_cnt) begin
        errors++;
        $display("FAIL rand%0d we_count: got %0d exp %0d",
                 it, we_seen, m_we_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    clear_obs();
    script.delete();
    script.push_back(w_start(1'b0));
    for (int i = 0; i < 4100; i++) script.push_back(w_data());
    script.push_back(w_term(7));
    run(1, 1'b1, script.size() + 3);
    expect_counts("saturate", 1, 0, 16'h7FFF);
  endtask

  initial begin
    set_mode(2);
    drive(w_empty());
    test_reset();
    test_5g_frame();
    test_2g5_lane4();
    test_back_to_back();
    test_underrun();
    test_split();
    test_reset_mode();
    test_inactive();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
